// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: word width, instruction codes and
// helpers classifying which instructions touch data memory.
package y86_pkg;

  localparam int WORD_W = 64;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  // Instructions that load a quad from data memory.
  function automatic logic is_mem_read(input logic [3:0] ic);
    return (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
  endfunction

  // Instructions that store a quad to data memory.
  function automatic logic is_mem_write(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
  endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Byte-addressed data memory: 8-byte little-endian combinational read,
// 8-byte synchronous write, synchronous clear on active-low reset.
// Byte indices wrap modulo MEM_BYTES; callers that need bounds
// enforcement gate wr_en and the read result themselves.
module y86_dmem_array #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  output logic [63:0]   rd_data,
  input  logic          wr_en,
  input  logic [63:0]   wr_data
);

  logic [7:0] mem_q [MEM_BYTES];
  logic [7:0] mem_d [MEM_BYTES];

  // Index of byte k of the quad starting at base, wrapped into the array.
  function automatic logic [AW-1:0] byte_idx(input logic [AW-1:0] base, input int k);
    return AW'((int'(base) + k) % MEM_BYTES);
  endfunction

  // Assemble the little-endian quad at addr.
  always_comb begin
    rd_data = 64'h0;
    for (int k = 0; k < 8; k++) begin
      rd_data[8*k +: 8] = mem_q[byte_idx(addr, k)];
    end
  end

  // Next memory contents: hold, or overlay the eight written bytes.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        mem_d[byte_idx(addr, k)] = wr_data[8*k +: 8];
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Memory register: clear every byte on reset, otherwise take next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/y86_data_memory.sv
// Y86-64 memory stage: decodes icode, selects address and write data,
// and performs the quad load/store against y86_dmem_array.
// Optional macro DMEM_BOUNDS_CHECK_EN: flag and suppress accesses whose
// last byte lies beyond MEM_BYTES; when undefined, addresses wrap.
module y86_data_memory
  import y86_pkg::*;
#(
  parameter int N         = WORD_W,
  parameter int MEM_BYTES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   icode,
  input  logic [N-1:0] valA,
  input  logic [N-1:0] valB,
  input  logic [N-1:0] valE,
  input  logic [N-1:0] valP,
  output logic [N-1:0] valM,
  output logic [N-1:0] memadr,
  output logic         dmem_error
);

  localparam int AW = $clog2(MEM_BYTES);

  logic         rd_s;
  logic         wr_s;
  logic         legal_s;
  logic         wr_en_s;
  logic [N-1:0] adr_s;
  logic [N-1:0] wdata_s;
  logic [AW-1:0] base_s;
  logic [63:0]  rd_data_s;
  logic         unused_valb_s;

  // valB only keeps the stage interface uniform with the other stages.
  assign unused_valb_s = ^valB;

  // Decode icode into access kind, effective address and store data.
  always_comb begin
    rd_s    = is_mem_read(icode);
    wr_s    = is_mem_write(icode);
    wdata_s = valA;
    adr_s   = {N{1'b0}};
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_PUSHQ: adr_s = valE;
      I_CALL: begin
        adr_s   = valE;
        wdata_s = valP;
      end
      I_RET, I_POPQ: adr_s = valA;
      default: adr_s = {N{1'b0}};
    endcase
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  // Legal only if the last byte (a + 7) is inside the array, no wrap.
  always_comb begin
    legal_s    = (adr_s <= N'(MEM_BYTES - 32'sd8));
    dmem_error = (rd_s | wr_s) & ~legal_s;
  end
`else
  // Without bounds checking every access proceeds, wrapping per byte.
  always_comb begin
    legal_s    = 1'b1;
    dmem_error = 1'b0;
  end
`endif

  // Array base index, write gating and result gating.
  always_comb begin
    base_s  = AW'(adr_s % N'(MEM_BYTES));
    wr_en_s = rst_n & wr_s & legal_s;
    memadr  = adr_s;
    if (rst_n && rd_s && legal_s) begin
      valM = rd_data_s;
    end else begin
      valM = {N{1'b0}};
    end
  end

  y86_dmem_array #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (base_s),
    .rd_data (rd_data_s),
    .wr_en   (wr_en_s),
    .wr_data (wdata_s)
  );

endmodule

// File: tb/tb_y86_data_memory.sv
// Self-checking bench for y86_data_memory: directed plan steps followed by
// randomized instructions compared against a byte-array reference model.
module tb_y86_data_memory;

  localparam int N         = 64;
  localparam int MEM_BYTES = 1024;

  logic         clk;
  logic         rst_n;
  logic [3:0]   icode;
  logic [N-1:0] valA, valB, valE, valP;
  logic [N-1:0] valM, memadr;
  logic         dmem_error;

  int n_checks;
  int n_pass;

  byte unsigned ref_mem [MEM_BYTES];

  y86_data_memory #(.N(N), .MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .icode      (icode),
    .valA       (valA),
    .valB       (valB),
    .valE       (valE),
    .valP       (valP),
    .valM       (valM),
    .memadr     (memadr),
    .dmem_error (dmem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_is_rd(input logic [3:0] ic);
    return ic == 4'd5 || ic == 4'd9 || ic == 4'd11;
  endfunction

  function automatic bit ref_is_wr(input logic [3:0] ic);
    return ic == 4'd4 || ic == 4'd8 || ic == 4'd10;
  endfunction

  function automatic logic [63:0] ref_adr(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e);
    if (ic == 4'd4 || ic == 4'd5 || ic == 4'd8 || ic == 4'd10) return e;
    if (ic == 4'd9 || ic == 4'd11) return a;
    return 64'd0;
  endfunction

  function automatic bit ref_legal(input logic [63:0] adr);
`ifdef DMEM_BOUNDS_CHECK_EN
    // a + 7 < MEM_BYTES in unbounded arithmetic
    return adr < 64'(MEM_BYTES) && (adr + 64'd7) < 64'(MEM_BYTES);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int ref_byte_at(input logic [63:0] adr, input int k);
    return int'((adr % 64'(MEM_BYTES) + 64'(k)) % 64'(MEM_BYTES));
  endfunction

  function automatic logic [63:0] ref_quad(input logic [63:0] adr);
    logic [63:0] q = 64'd0;
    for (int k = 7; k >= 0; k--) q = (q << 8) | 64'(ref_mem[ref_byte_at(adr, k)]);
    return q;
  endfunction

  // Apply one instruction: check combinational outputs, clock it, update model.
  task automatic do_op(input string tag, input logic r, input logic [3:0] ic,
                       input logic [63:0] a, input logic [63:0] e, input logic [63:0] p);
    logic [63:0] adr, exp_m, wd;
    bit err;
    rst_n = r; icode = ic; valA = a; valE = e; valP = p; valB = 64'(~a);
    #1;
    adr   = ref_adr(ic, a, e);
    err   = (ref_is_rd(ic) || ref_is_wr(ic)) && !ref_legal(adr);
    exp_m = (r && ref_is_rd(ic) && ref_legal(adr)) ? ref_quad(adr) : 64'd0;
    check_eq({tag, ".valM"}, valM, exp_m);
    check_eq({tag, ".memadr"}, memadr, adr);
    check_eq({tag, ".err"}, 64'(dmem_error), 64'(err));
    @(posedge clk);
    if (!r) begin
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    end else if (ref_is_wr(ic) && ref_legal(adr)) begin
      wd = (ic == 4'd8) ? p : a;
      for (int k = 0; k < 8; k++) ref_mem[ref_byte_at(adr, k)] = wd[8*k +: 8];
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] ra, re, rp;
    logic [3:0]  ric;
    logic        rr;
    n_checks = 0;
    n_pass   = 0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    rst_n = 1'b0; icode = 4'd0; valA = 64'd0; valB = 64'd0; valE = 64'd0; valP = 64'd0;
    @(negedge clk);

    // Directed plan
    do_op("reset",    1'b0, 4'd5,  64'd0,  64'd0,  64'd0);
    do_op("rd0",      1'b1, 4'd5,  64'd0,  64'd0,  64'd0);
    do_op("rmmovq",   1'b1, 4'd4,  64'd29, 64'd14, 64'd0);
    do_op("mrmovq14", 1'b1, 4'd5,  64'd0,  64'd14, 64'd0);
    check_eq("plan.ld14", valM, 64'd29);
    do_op("mrmovq15", 1'b1, 4'd5,  64'd0,  64'd15, 64'd0);
    do_op("call",     1'b1, 4'd8,  64'd0,  64'd18, 64'd40);
    do_op("ret",      1'b1, 4'd9,  64'd18, 64'd0,  64'd0);
    do_op("pushq",    1'b1, 4'd10, 64'h0102030405060708, 64'd20, 64'd0);
    do_op("popq",     1'b1, 4'd11, 64'd20, 64'd0,  64'd0);
    do_op("opq",      1'b1, 4'd6,  64'd0,  64'd14, 64'd0);
    do_op("reld14",   1'b1, 4'd5,  64'd0,  64'd14, 64'd0);
    do_op("edgewr",   1'b1, 4'd4,  64'hDEADBEEFCAFEF00D, 64'(MEM_BYTES - 4), 64'd0);
    do_op("edgerd",   1'b1, 4'd5,  64'd0,  64'(MEM_BYTES - 4), 64'd0);
    do_op("lastok",   1'b1, 4'd10, 64'h1122334455667788, 64'(MEM_BYTES - 8), 64'd0);
    do_op("lastrd",   1'b1, 4'd11, 64'(MEM_BYTES - 8), 64'd0, 64'd0);
    do_op("rstwr",    1'b0, 4'd4,  64'hFFFF, 64'd100, 64'd0);
    do_op("afterrst", 1'b1, 4'd5,  64'd0,  64'd14, 64'd0);

    // Randomized instructions, addresses clustered near both ends of memory
    for (int t = 0; t < 400; t++) begin
      ric = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 11));
      case ($urandom_range(0, 5))
        0:       re = 64'($urandom_range(MEM_BYTES - 16, MEM_BYTES + 8));
        1:       re = {$urandom, $urandom};
        default: re = 64'($urandom_range(0, 63));
      endcase
      ra = ($urandom_range(0, 1) == 1) ? re : {$urandom, $urandom};
      if (ric == 4'd9 || ric == 4'd11) ra = re;
      rp = {$urandom, $urandom};
      rr = ($urandom_range(0, 49) != 0);
      do_op("rand", rr, ric, ra, re, rp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/y86_data_memory.md
Name: y86_data_memory

Overview:
- Memory stage of the sequential Y86-64 processor.
- Decodes icode and selects the data-memory address; performs the 8-byte little-endian quad read or write that the instruction requires.
- Outputs the loaded value valM and the effective address memadr to write-back and PC-update logic.
- Sits between the execute stage (supplies valE) and write-back.

Parameters:
- N, 64, datapath width of valA/valB/valE/valP/valM/memadr.
- MEM_BYTES, 1024, data-memory size in bytes (byte-addressed).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- icode  input  4  instruction code of the current instruction.
- valA  input  N  register operand A; write data for rmmovq/pushq; address for ret/popq.
- valB  input  N  register operand B; unused by this stage, accepted for interface uniformity.
- valE  input  N  ALU result; address for rmmovq/mrmovq/call/pushq.
- valP  input  N  incremented PC; write data for call.
- valM  output  N  value read from memory (combinational).
- memadr  output  N  effective memory address (combinational).
- dmem_error  output  1  address out of range for an access (see Optional Feature).

Behaviour:
- icode map:
  - 4 rmmovq: write valA to M[valE].
  - 5 mrmovq: read M[valE].
  - 8 call: write valP to M[valE].
  - 9 ret: read M[valA].
  - 10 pushq: write valA to M[valE].
  - 11 popq: read M[valA].
  - All other icodes: no access.
- memadr:
  - valE for icodes 4, 5, 8, 10.
  - valA for icodes 9, 11.
  - 0 otherwise.
- Storage: MEM_BYTES x 8-bit array. A quad at address a occupies bytes a..a+7; byte a is least significant (little-endian).
- Read path:
  - valM is combinational: {M[a+7],...,M[a]} for read icodes.
  - valM = 0 for non-read icodes and whenever rst_n = 0.
- Write path:
  - On rising clk with rst_n = 1 and a write icode, all 8 bytes are written in the same edge.
  - A read after the write edge returns the new data (write-then-read across cycles).
- Reset: on a rising clk with rst_n = 0, every memory byte is cleared to 0 and no write occurs. Reset asserted mid-operation suppresses the pending write.
- Unwritten locations read as 0.
- Width rule: the address is the full N-bit value. An access is legal only when a + 7 < MEM_BYTES, evaluated without wrap-around.
- Illegal access:
  - The write is suppressed.
  - valM = 0.
- No handshake; single-cycle stage.

Optional Feature:
- Macro DMEM_BOUNDS_CHECK_EN.
- Defined:
  - dmem_error = 1 combinationally whenever a read or write icode addresses out of range.
  - Illegal accesses behave as in Behaviour.
- Undefined:
  - dmem_error is tied 0.
  - The address is reduced modulo MEM_BYTES per byte (wrap).
  - Every access proceeds.

Decomposition:
- Shared package y86_pkg: icode constants (I_HALT=0, I_NOP=1, I_RRMOVQ=2, I_IRMOVQ=3, I_RMMOVQ=4, I_MRMOVQ=5, I_OPQ=6, I_JXX=7, I_CALL=8, I_RET=9, I_PUSHQ=10, I_POPQ=11) and word width 64.
- One sub-module y86_dmem_array holds the byte array. It provides the 8-byte little-endian combinational read, the synchronous write and the synchronous clear.
- The top module does icode decode, address/data select and the bounds check.

Test Plan:
- Reset: rst_n = 0 for one edge, then icode = 5, valE = 0 -> valM = 0, memadr = 0.
- Store/load: icode = 4, valE = 14, valA = 29 -> memadr = 14, valM = 0. After the edge, icode = 5, valE = 14 -> valM = 29. With valE = 15 -> valM = 0.
- Call/ret: icode = 8, valE = 18, valP = 40 -> memadr = 18. After the edge, icode = 9, valA = 18 -> valM = 40, memadr = 18.
- Push/pop: icode = 10, valE = 20, valA = 0x0102030405060708. After the edge, icode = 11, valA = 20 -> valM = 0x0102030405060708. Byte 20 reads 0x08 via a quad read at 20.
- Non-memory icode 6 with valE = 14 -> memadr = 0, valM = 0, memory unchanged on the edge.
- Bounds (macro defined): icode = 4, valE = MEM_BYTES-4 -> dmem_error = 1, no write. icode = 5, same address -> valM = 0, dmem_error = 1.
